// File: rtl/clock_div_meter_pkg.sv
// Shared types and constants for the divided-clock meter.
package clock_div_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // Bit positions inside the 8-bit status byte
    localparam int FACTOR_LSB = 0;
    localparam int FACTOR_W   = 3;
    localparam int VALID      = 3;
    localparam int MATCH      = 4;
    localparam int STALL      = 5;
    localparam int GLITCH     = 6;
    localparam int EDGE       = 7;

    // Bit positions inside the 8-bit control byte
    localparam int IN_CLK     = 0;
    localparam int IN_ENABLE  = 1;
    localparam int IN_EXP_LSB = 2;

    // Largest divide factor the 3-bit result field can report
    localparam int MAX_FACTOR = 7;

endpackage

// File: rtl/clock_div_meter_if.sv
// Tiny-user 8-bit pin bundle: control/measured clock in, status byte out.
interface clock_div_meter_if;
    logic [7:0] io_in;
    logic [7:0] out;

    // Driver side (stimulus / host)
    modport master (output io_in, input out);

    // Meter side
    modport slave (input io_in, output out);
endinterface

// File: rtl/clock_div_meter_edge_sync.sv
// Synchronizes the measured clock into clk and flags every toggle.
module clock_div_meter_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the pin through the synchronizer chain; history trails the last stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Both polarities count as an edge
    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/clock_div_meter.sv
// Divided-clock meter: measures toggle spacing on io_in[0], recovers the
// divide factor, locks on repeated equal readings and reports status.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | disabled; all measurement state cleared
// ARM    | waiting for the first edge to start an interval
// TRACK  | collecting equal measurements toward lock
// LOCKED | factor confirmed; any different interval is a glitch
module clock_div_meter
    import clock_div_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT     = 16,
    parameter int LOCK_COUNT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    clock_div_meter_if.slave tiny
);

    // One spare count value so LOCK_COUNT=1 can still increment without wrap
    localparam int                MC_W    = $clog2(LOCK_COUNT + 2);
    localparam logic [MC_W-1:0]   LOCK_MC = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  MAX_M   = CNT_W'(MAX_FACTOR);

    logic                en;
    logic [2:0]          exp_factor;
    logic                edge_det;
    logic                unused_io;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MC_W-1:0]     mc_q, mc_d;
    logic [MC_W-1:0]     mc_upd;
    logic [2:0]          factor_q, factor_d;
    logic                valid_q, valid_d;
    logic                match_q, match_d;
    logic                stall_q, stall_d;
    logic                glitch_q, glitch_d;
    logic                edge_out_q, edge_out_d;

    logic                timeout;
    logic                m_in_range;
    logic [2:0]          m_fac;
    logic                m_eq;

    assign en         = tiny.io_in[IN_ENABLE];
    assign exp_factor = tiny.io_in[IN_EXP_LSB +: 3];
    assign unused_io  = ^tiny.io_in[7:5];

    clock_div_meter_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (tiny.io_in[IN_CLK]),
        .edge_det (edge_det)
    );

    // The counter value at an edge is the measurement m
    assign timeout    = (cnt_q == TMO);
    assign m_in_range = (cnt_q <= MAX_M);
    assign m_fac      = cnt_q[2:0];
    assign m_eq       = m_in_range && (m_fac == factor_q);

    // Interval counter: restarts on each edge, saturates at the timeout value
    always_comb begin
        cnt_d = cnt_q;
        if (!en || state_q == IDLE) begin
            cnt_d = '0;
        end else if (edge_det) begin
            cnt_d = '0;
        end else if (cnt_q != TMO) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and status update; disable overrides every other event
    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        mc_upd   = '0;
        factor_d = factor_q;
        valid_d  = valid_q;
        stall_d  = stall_q;
        glitch_d = glitch_q;

        if (!en) begin
            state_d  = IDLE;
            mc_d     = '0;
            factor_d = '0;
            valid_d  = 1'b0;
            stall_d  = 1'b0;
            glitch_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (edge_det) begin
                        state_d = TRACK;
                        mc_d    = '0;
                    end else if (timeout) begin
                        stall_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (edge_det) begin
                        if (!m_in_range) begin
                            mc_upd = '0;
                        end else if (mc_q == '0 || !m_eq) begin
                            factor_d = m_fac;
                            mc_upd   = MC_W'(1);
                        end else begin
                            mc_upd = mc_q + MC_W'(1);
                        end
                        mc_d = mc_upd;
                        if (mc_upd >= LOCK_MC) begin
                            state_d = LOCKED;
                            valid_d = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d = ARM;
                        stall_d = 1'b1;
                        valid_d = 1'b0;
                        mc_d    = '0;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (!m_eq) begin
                            state_d  = TRACK;
                            glitch_d = 1'b1;
                            valid_d  = 1'b0;
                            if (m_in_range) begin
                                factor_d = m_fac;
                                mc_d     = MC_W'(1);
                            end else begin
                                mc_d     = '0;
                            end
                        end
                    end else if (timeout) begin
                        state_d = ARM;
                        stall_d = 1'b1;
                        valid_d = 1'b0;
                        mc_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Match follows valid one cycle later, but drops together with a disable
    always_comb begin
        match_d    = en && valid_q && (factor_q == exp_factor);
        edge_out_d = edge_det;
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mc_q       <= '0;
            factor_q   <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            stall_q    <= 1'b0;
            glitch_q   <= 1'b0;
            edge_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mc_q       <= mc_d;
            factor_q   <= factor_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            stall_q    <= stall_d;
            glitch_q   <= glitch_d;
            edge_out_q <= edge_out_d;
        end
    end

    // Pack the status byte
    always_comb begin
        tiny.out                            = '0;
        tiny.out[FACTOR_LSB +: FACTOR_W]    = factor_q;
        tiny.out[VALID]                     = valid_q;
        tiny.out[MATCH]                     = match_q;
        tiny.out[STALL]                     = stall_q;
        tiny.out[GLITCH]                    = glitch_q;
        tiny.out[EDGE]                      = edge_out_q;
    end

endmodule
